// File: rtl/im_fetch_ctrl.sv
// rtl/im_fetch_ctrl.sv - instruction fetch sequencer with in-order prefetch queue and redirect flush
module im_fetch_ctrl #(
  parameter int          DEPTH    = 4,
  parameter int          IM_WORDS = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_done,
  output logic        misalign_err,
  output logic [15:0] fetch_cnt
);

  localparam int          PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW       = $clog2(DEPTH + 1);
  localparam logic [31:0] PC_LIMIT = 32'(IM_WORDS) * 32'd4;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [15:0]     fetch_cnt_q, fetch_cnt_d;
  logic            misalign_q, misalign_d;
  logic [31:0]     instr_q [DEPTH];
  logic [31:0]     ipc_q   [DEPTH];

  logic            pc_in_range;
  logic            redir_act;
  logic [31:0]     redir_pc_al;
  logic            redir_in_range;
  logic            start_act;
  logic            push;
  logic            pop;

  // A redirect is meaningful only once fetching has begun; in IDLE it is dropped.
  assign pc_in_range    = (pc_q < PC_LIMIT);
  assign redir_act      = redirect_valid && (state_q != S_IDLE);
  assign redir_pc_al    = {redirect_pc[31:2], 2'b00};
  assign redir_in_range = (redir_pc_al < PC_LIMIT);
  assign start_act      = start && (state_q == S_IDLE);
  // Full check uses the registered count, so a same-cycle pop never frees a slot early.
  assign push = (state_q == S_FETCH) && pc_in_range && (count_q < DEPTH_C) && !redirect_valid;
  assign pop  = (count_q != '0) && instr_ready;

  // Next-state logic: redirect overrides normal progress from FETCH or DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: if (!pc_in_range) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (redir_act) begin
      state_d = redir_in_range ? S_FETCH : S_DONE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath next values: PC, queue occupancy/pointers, push counter, misalign pulse.
  always_comb begin
    pc_d        = pc_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    fetch_cnt_d = fetch_cnt_q;
    misalign_d  = 1'b0;

    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      pc_d     = pc_q + 32'd4;
      if (fetch_cnt_q != 16'hFFFF) fetch_cnt_d = fetch_cnt_q + 16'd1;
    end
    count_d = count_q + CW'(push) - CW'(pop);

    if (start_act) begin
      pc_d        = RESET_PC;
      fetch_cnt_d = 16'd0;
    end

    // Flush after the same-cycle pop; pointers restart at slot 0.
    if (redir_act) begin
      pc_d       = redir_pc_al;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      misalign_d = (redirect_pc[1:0] != 2'b00);
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fetch_cnt_q <= 16'd0;
      misalign_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fetch_cnt_q <= fetch_cnt_d;
      misalign_q  <= misalign_d;
    end
  end

  // Queue storage: each entry pairs the fetched word with the PC it came from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= 32'd0;
        ipc_q[i]   <= 32'd0;
      end
    end else if (push) begin
      instr_q[wr_ptr_q] <= im_instr;
      ipc_q[wr_ptr_q]   <= pc_q;
    end
  end

  assign im_addr      = pc_q;
  assign instr_valid  = (count_q != '0);
  assign instr        = instr_q[rd_ptr_q];
  assign instr_pc     = ipc_q[rd_ptr_q];
  assign fetch_done   = (state_q == S_DONE);
  assign misalign_err = misalign_q;
  assign fetch_cnt    = fetch_cnt_q;

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// tb/tb_im_fetch_ctrl.sv - directed-vector bench for im_fetch_ctrl
module tb_im_fetch_ctrl;

  localparam int DEPTH    = 4;
  localparam int IM_WORDS = 6;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_done;
  logic        misalign_err;
  logic [15:0] fetch_cnt;

  int n_vec;
  int n_err;

  im_fetch_ctrl #(
    .DEPTH    (DEPTH),
    .IM_WORDS (IM_WORDS),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .im_addr        (im_addr),
    .im_instr       (im_instr),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_done     (fetch_done),
    .misalign_err   (misalign_err),
    .fetch_cnt      (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] im_word(input int k);
    return 32'hC0DE_0000 + 32'(k);
  endfunction

  // Combinational IM model: words 0..IM_WORDS-1 preloaded, junk beyond.
  always_comb begin
    im_instr = 32'hDEAD_BEEF;
    if (im_addr[31:2] < 30'(IM_WORDS)) im_instr = im_word(int'(im_addr[31:2]));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    start          = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
  endtask

  // With ready high, one new head per cycle: words first..last in order.
  task automatic stream_chk(input string tag, input int first, input int last);
    for (int w = first; w <= last; w++) begin
      tick();
      chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
      chk({tag, "_pc"}, instr_pc, 32'(w * 4));
      chk({tag, "_instr"}, instr, im_word(w));
    end
  endtask

  task automatic expect_done(input string tag, input logic [15:0] cnt);
    tick();
    chk({tag, "_done"}, 32'(fetch_done), 32'd1);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_cnt"}, 32'(fetch_cnt), 32'(cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] seen_pc [$];
  logic [31:0] seen_in [$];

  initial begin
    n_vec = 0;
    n_err = 0;

    // Reset values
    do_reset();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_addr", im_addr, 32'd0);
    chk("rst_done", 32'(fetch_done), 32'd0);
    chk("rst_mis", 32'(misalign_err), 32'd0);
    chk("rst_cnt", 32'(fetch_cnt), 32'd0);

    // Redirect in IDLE is ignored
    redirect(32'h0000_0006);
    chk("idle_redir_addr", im_addr, 32'd0);
    chk("idle_redir_mis", 32'(misalign_err), 32'd0);
    chk("idle_redir_done", 32'(fetch_done), 32'd0);

    // Straight run with ready high
    instr_ready = 1'b1;
    pulse_start();
    chk("t1_lat_valid", 32'(instr_valid), 32'd0);
    stream_chk("t1", 0, 5);
    expect_done("t1_end", 16'd6);

    // Start outside IDLE is ignored
    pulse_start();
    chk("done_start_ign", 32'(fetch_done), 32'd1);

    // Backpressure: queue fills to DEPTH, pc stalls at 16
    do_reset();
    pulse_start();
    repeat (5) tick();
    chk("t2_stall_addr", im_addr, 32'd16);
    chk("t2_stall_cnt", 32'(fetch_cnt), 32'd4);
    chk("t2_stall_pc", instr_pc, 32'd0);
    instr_ready = 1'b1;
    seen_pc.delete();
    seen_in.delete();
    for (int c = 0; c < 30 && seen_pc.size() < 8; c++) begin
      if (instr_valid) begin
        seen_pc.push_back(instr_pc);
        seen_in.push_back(instr);
      end
      tick();
      if (fetch_done && !instr_valid) break;
    end
    chk("t2_n_seen", 32'(seen_pc.size()), 32'd6);
    for (int k = 0; k < seen_pc.size() && k < 6; k++) begin
      chk("t2_order_pc", seen_pc[k], 32'(k * 4));
      chk("t2_order_in", seen_in[k], im_word(k));
    end
    chk("t2_done", 32'(fetch_done), 32'd1);

    // Redirect flush while queue holds PCs 4..16
    do_reset();
    pulse_start();
    repeat (5) tick();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    tick();
    chk("t3_pre_head", instr_pc, 32'd4);
    chk("t3_pre_cnt", 32'(fetch_cnt), 32'd5);
    chk("t3_pre_addr", im_addr, 32'd20);
    redirect(32'd8);
    chk("t3_flush_valid", 32'(instr_valid), 32'd0);
    chk("t3_flush_addr", im_addr, 32'd8);
    chk("t3_flush_mis", 32'(misalign_err), 32'd0);
    instr_ready = 1'b1;
    stream_chk("t3", 2, 5);
    expect_done("t3_end", 16'd9);

    // Misaligned redirect from DONE
    redirect(32'h0000_0006);
    chk("t4_mis_pulse", 32'(misalign_err), 32'd1);
    chk("t4_addr", im_addr, 32'd4);
    chk("t4_not_done", 32'(fetch_done), 32'd0);
    chk("t4_valid0", 32'(instr_valid), 32'd0);
    tick();
    chk("t4_mis_clear", 32'(misalign_err), 32'd0);
    chk("t4_first_pc", instr_pc, 32'd4);
    chk("t4_first_in", instr, im_word(1));
    stream_chk("t4", 2, 5);
    expect_done("t4_end", 16'd14);

    // DONE -> redirect to 0 resumes; head appears two cycles after redirect
    redirect(32'd0);
    chk("t5_valid0", 32'(instr_valid), 32'd0);
    chk("t5_not_done", 32'(fetch_done), 32'd0);
    stream_chk("t5", 0, 5);
    expect_done("t5_end", 16'd20);

    // Redirect exactly to the end of the image stays in DONE
    redirect(32'd24);
    chk("t5_oor_done", 32'(fetch_done), 32'd1);
    chk("t5_oor_addr", im_addr, 32'd24);
    tick();
    chk("t5_oor_valid", 32'(instr_valid), 32'd0);
    chk("t5_oor_cnt", 32'(fetch_cnt), 32'd20);

    // Asynchronous reset mid-stream with 3 entries queued
    do_reset();
    pulse_start();
    repeat (3) tick();
    chk("t6_pre_valid", 32'(instr_valid), 32'd1);
    chk("t6_pre_addr", im_addr, 32'd12);
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(instr_valid), 32'd0);
    chk("t6_async_addr", im_addr, 32'd0);
    chk("t6_async_cnt", 32'(fetch_cnt), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    instr_ready = 1'b1;
    repeat (3) tick();
    chk("t6_idle_valid", 32'(instr_valid), 32'd0);
    chk("t6_idle_addr", im_addr, 32'd0);
    pulse_start();
    tick();
    chk("t6_resume_valid", 32'(instr_valid), 32'd1);
    chk("t6_resume_pc", instr_pc, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/im_fetch_ctrl.md
Name: im_fetch_ctrl

Overview:
Sequences instruction fetch from the combinational instruction memory (IM) for the single-cycle/pipelined MIPS core. Holds the PC, drives the IM word address, and captures returned instructions with their PCs into a small in-order prefetch queue. Presents them to decode over a valid/ready handshake. Handles branch/jump redirects (flush and refetch) and stops at the end of the IM image.

Parameters:
DEPTH, 4, prefetch queue entries; power of two, 2..16
IM_WORDS, 32, number of valid 32-bit IM words; fetch stops at byte address IM_WORDS*4
RESET_PC, 32'h0000_0000, PC loaded at reset and on start; word aligned

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins fetching at RESET_PC (honoured only in IDLE)
im_addr  out  32  byte address to IM Addr_in; always equals pc register
im_instr  in  32  IM read data, combinational from im_addr in the same cycle
instr_valid  out  1  queue head valid
instr  out  32  queue head instruction
instr_pc  out  32  byte PC of queue head
instr_ready  in  1  decode accepts head when instr_valid&&instr_ready
redirect_valid  in  1  branch/jump taken; one cycle
redirect_pc  in  32  redirect target byte address
fetch_done  out  1  high in DONE state
misalign_err  out  1  one-cycle pulse when redirect_pc[1:0]!=0
fetch_cnt  out  16  instructions pushed since last start, saturating at 16'hFFFF

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, queue count=0, rd/wr pointers=0, instr_valid=0, instr=0, instr_pc=0, fetch_done=0, misalign_err=0, fetch_cnt=0. Release is synchronous to clk. Reset mid-fetch discards all queue contents.
- States: IDLE, FETCH, DONE.
  - IDLE -> FETCH on start; pc<=RESET_PC; fetch_cnt<=0.
  - FETCH -> DONE when pc >= IM_WORDS*4; no push occurs that cycle.
  - DONE -> FETCH only on redirect with an in-range target.
  - start outside IDLE is ignored. redirect in IDLE is ignored.
- Push condition: state==FETCH && pc < IM_WORDS*4 && count < DEPTH (count registered before this cycle's pop) && !redirect_valid.
  - On push: entry <= {im_instr, pc}; pc <= pc+4; fetch_cnt++ (saturating).
  - When full, no push occurs even if a pop happens the same cycle; the next push follows one cycle later.
- Pop: instr_valid && instr_ready advances the head.
  - instr_valid = (count!=0); instr and instr_pc are registered and driven from the head entry.
  - Head is stable while valid && !ready.
- Simultaneous push and pop: count unchanged; both pointers advance, wrapping modulo DEPTH.
- Redirect (highest priority):
  - Same-cycle pop still completes.
  - Then the whole queue is flushed (count=0), pc <= {redirect_pc[31:2],2'b00}, and state <= FETCH.
  - The first post-redirect instruction is pushed on the next cycle and is valid at the output the cycle after.
  - If redirect_pc[1:0]!=0, misalign_err pulses 1 cycle and the aligned address is used.
  - If the aligned target is >= IM_WORDS*4, state goes to DONE.
- Latency: start at edge N -> first push at edge N+1 -> instr_valid=1 after edge N+1.
- Throughput: 1 instruction/cycle with instr_ready held high.

Test Plan:
- IM words 0..5 preloaded; bench parameter IM_WORDS=6; start, ready=1 -> instr_pc 0,4,...,20 on consecutive cycles with matching instr; then fetch_done=1, fetch_cnt=6, instr_valid=0.
- ready=0 after start -> exactly DEPTH=4 pushes (pc stalls at 16). Raise ready -> PCs 0,4,8,12,16,20 in order; none lost or duplicated.
- Redirect to 8 while queue holds PCs 4..16 -> next valid instr_pc=8, then 12; the old entries 12 and 16 never appear.
- Redirect to 32'h0000_0006 -> misalign_err pulses 1 cycle; next instr_pc=4.
- DONE state, redirect to 0 -> FETCH resumes; instr_pc=0 appears two cycles later.
- rst_n asserted low mid-stream with 3 entries queued -> instr_valid=0 and im_addr=RESET_PC immediately; start is required to resume.
